// File: rtl/sobel_raster_writer.sv
// sobel_raster_writer: writes Sobel results to the frame buffer at window centers; SOBEL_BORDER_ZERO_EN adds a border-zeroing walk per frame
module sobel_raster_writer #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE = 10,
  parameter int NUM_ROWS = 10,
  parameter int BUFFER_SIZE = 3,
  localparam int ADDR_W = $clog2(ROW_SIZE*NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 frame_done
);
  localparam int B = (BUFFER_SIZE-1)/2;
  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(NUM_ROWS);
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic mem_we_d, frame_done_d, xfer, adv, c_end, last, full;
  logic [ADDR_W-1:0] mem_addr_d, waddr;
  logic [WORD_SIZE-1:0] mem_wdata_d;
  assign xfer = in_valid && in_ready;
  assign c_end = int'(c_q) == ROW_SIZE-1;
  assign last = c_end && int'(r_q) == NUM_ROWS-1;
  assign full = int'(r_q) >= BUFFER_SIZE-1 && int'(c_q) >= BUFFER_SIZE-1;
  assign waddr = ADDR_W'((int'(r_q)-B)*ROW_SIZE + int'(c_q) - B);
`ifdef SOBEL_BORDER_ZERO_EN
  localparam logic [0:0] STREAM = 1'b0;
  localparam logic [0:0] BORDER = 1'b1;
  logic [0:0] st_q, st_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic walk, on_border;
  // r/c are both 0 on entry to BORDER, so they double as the walk's row/col of k
  assign walk = st_q == BORDER;
  assign on_border = int'(r_q) < B || int'(r_q) >= NUM_ROWS-B || int'(c_q) < B || int'(c_q) >= ROW_SIZE-B;
  assign in_ready = !reset && !walk;
  assign adv = xfer || walk;
  always_comb begin
    st_d = walk ? (last ? STREAM : BORDER) : (xfer && last ? BORDER : STREAM);
    k_d = walk && !last ? k_q + 1'b1 : '0;
    mem_we_d = walk ? on_border : xfer && full;
    mem_addr_d = walk ? k_q : waddr;
    mem_wdata_d = walk ? '0 : in_data;
    frame_done_d = walk && last;
  end
  always_ff @(posedge clk) begin
    st_q <= reset ? STREAM : st_d;
    k_q <= reset ? '0 : k_d;
  end
`else
  assign in_ready = !reset;
  assign adv = xfer;
  always_comb begin
    mem_we_d = xfer && full;
    mem_addr_d = waddr;
    mem_wdata_d = in_data;
    frame_done_d = xfer && last;
  end
`endif
  always_comb begin
    c_d = adv ? (c_end ? '0 : c_q + 1'b1) : c_q;
    r_d = adv && c_end ? (last ? '0 : r_q + 1'b1) : r_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
      r_q <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      frame_done <= 1'b0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      mem_we <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      frame_done <= frame_done_d;
    end
  end
endmodule
